connection_bank: RTL

Trainable weight store for `NUM_CONN` neural-net connections in signed Q(`FIXED_BITS`.`FRACTIONAL_BITS`) format. It generalises the single, non-trainable connection. Each entry holds a weight, an accumulated gradient and the previous delta-weight. A sequential update engine applies a momentum step to every entry in turn: delta = eta·gradient + alpha·prev_delta, then weight += delta. It sits between the backprop gradient source and the neuron MAC datapath, which reads weights through a registered read port.

---
 rtl/connection_bank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/connection_bank.sv
// Purpose: trainable weight store for NUM_CONN signed Q(FIXED_BITS.FRACTIONAL_BITS) connections with a momentum update engine.
// Latency: rd_* registered (1 cycle); a sweep takes NUM_CONN+1 cycles from update_start to the done pulse.
// Backpressure: none; wr_en, grad_valid and update_start are dropped (not queued) while a sweep is in progress or done is high.
//
// Ports:
//   clk, rst                      single clock, async active-high reset
//   wr_en/wr_addr/wr_weight       load a weight (clears that entry's grad and prev_delta)
//   grad_valid/grad_addr/grad_in  saturating gradient accumulate
//   update_start/eta/alpha        start a sweep; eta and alpha latched on the start cycle
//   rd_addr -> rd_weight/rd_delta registered read port (out-of-range reads return 0)
//   busy, done                    sweep in progress / one-cycle end-of-sweep pulse
module connection_bank #(
  parameter int  NUM_CONN        = 4,
  parameter int  FIXED_BITS      = 8,
  parameter int  FRACTIONAL_BITS = 8,
  localparam int W               = FIXED_BITS + FRACTIONAL_BITS,
  localparam int AW              = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_weight,
  input  logic                grad_valid,
  input  logic [AW-1:0]       grad_addr,
  input  logic signed [W-1:0] grad_in,
  input  logic                update_start,
  input  logic signed [W-1:0] eta,
  input  logic signed [W-1:0] alpha,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_weight,
  output logic signed [W-1:0] rd_delta,
  output logic                busy,
  output logic                done
);

  localparam logic [AW:0]   CONN_LIM = (AW+1)'(NUM_CONN);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CONN - 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t              state;
  logic [AW-1:0]       idx;
  logic signed [W-1:0] eta_q;
  logic signed [W-1:0] alpha_q;

  logic signed [W-1:0] weight_mem [NUM_CONN];
  logic signed [W-1:0] grad_mem   [NUM_CONN];
  logic signed [W-1:0] pdelta_mem [NUM_CONN];

  // Clamp a W+1-bit two's-complement sum into W bits.
  function automatic logic signed [W-1:0] sat(input logic [W:0] x);
    if (x[W] != x[W-1])
      return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      return x[W-1:0];
  endfunction

  logic rd_ok, wr_ok, grad_ok, grad_take;
  assign rd_ok   = ({1'b0, rd_addr}   < CONN_LIM);
  assign wr_ok   = ({1'b0, wr_addr}   < CONN_LIM);
  assign grad_ok = ({1'b0, grad_addr} < CONN_LIM);
  // A load to the same entry in the same cycle wins over the gradient sample.
  assign grad_take = grad_valid && grad_ok && !(wr_en && wr_ok && (wr_addr == grad_addr));

  logic [W:0] grad_sum;
  assign grad_sum = {grad_mem[grad_addr][W-1], grad_mem[grad_addr]} + {grad_in[W-1], grad_in};

  // Momentum step for entry idx. Full-width products, arithmetic shift back
  // to Q format (floor), then a W+1-bit sum before saturation.
  logic signed [2*W-1:0] p1, p2;
  logic [W:0]            p1_t, p2_t, d_sum, w_sum;
  logic signed [W-1:0]   d, w_next;

  assign p1    = {{W{eta_q[W-1]}},   eta_q}   * {{W{grad_mem[idx][W-1]}},   grad_mem[idx]};
  assign p2    = {{W{alpha_q[W-1]}}, alpha_q} * {{W{pdelta_mem[idx][W-1]}}, pdelta_mem[idx]};
  assign p1_t  = (W+1)'(p1 >>> FRACTIONAL_BITS);
  assign p2_t  = (W+1)'(p2 >>> FRACTIONAL_BITS);
  assign d_sum = p1_t + p2_t;
  assign d     = sat(d_sum);
  assign w_sum = {weight_mem[idx][W-1], weight_mem[idx]} + {d[W-1], d};
  assign w_next = sat(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eta_q     <= '0;
      alpha_q   <= '0;
      rd_weight <= '0;
      rd_delta  <= '0;
      for (int k = 0; k < NUM_CONN; k++) begin
        weight_mem[k] <= '0;
        grad_mem[k]   <= '0;
        pdelta_mem[k] <= '0;
      end
    end else begin
      // Reads see the array before this edge's writes.
      rd_weight <= rd_ok ? weight_mem[rd_addr] : '0;
      rd_delta  <= rd_ok ? pdelta_mem[rd_addr] : '0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grad_take)
            grad_mem[grad_addr] <= sat(grad_sum);
          if (wr_en && wr_ok) begin
            weight_mem[wr_addr] <= wr_weight;
            grad_mem[wr_addr]   <= '0;
            pdelta_mem[wr_addr] <= '0;
          end
          if (update_start) begin
            state   <= S_UPDATE;
            idx     <= '0;
            busy    <= 1'b1;
            eta_q   <= eta;
            alpha_q <= alpha;
          end
        end

        S_UPDATE: begin
          weight_mem[idx] <= w_next;
          pdelta_mem[idx] <= d;
          grad_mem[idx]   <= '0;
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
